ctrl_fsm: RTL and testbench

Multi-cycle main control unit for the 16-bit CPU. It sequences each instruction through fetch, decode, execute, memory and write-back. It latches the fields that the ALU control decoder consumes: `opcode` and `func` go to the ALU control, which turns them into an ALU code. It also drives all datapath strobes, handshakes with instruction/data memory, and counts retired instructions.

---
 rtl/ctrl_fsm.sv | 187 ++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/HALT for the 16-bit CPU.
// Latency: 4 cycles R/addi/subi/st, 5 ld, 3 beq, 2 illegal/halt, plus one per memory wait cycle.
// Backpressure: FETCH and MEM hold with stable request/address-select until mem_ready.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   instr               - IR contents from the datapath (only sampled in DECODE)
//   mem_ready           - memory completes the current access this cycle
//   zero                - ALU zero flag, meaningful in EXEC
//   opcode, func        - fields latched in DECODE, feed the ALU control decoder
//   mem_re/mem_we/iord  - memory request strobes and address select (0 = PC, 1 = ALU)
//   ir_we/pc_we/pc_src  - IR/PC load strobes, PC source (1 = branch target)
//   alu_src_imm         - ALU B operand select (1 = sign-extended imm7)
//   reg_we/mem_to_reg   - register write strobe and write-back source
//   illegal             - one-cycle pulse in DECODE on an undefined encoding
//   halted              - high while in HALT
//   retired             - free-running retired-instruction counter (wraps)
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [2:0]  opcode,
    output logic [3:0]  func,
    output logic        mem_re,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_SUBI  = 3'b010;
    localparam logic [2:0] OP_ST    = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_BAD   = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t state, state_nxt;

    // Raw (pre-reset-gating) strobes from the next-state decoder.
    logic mem_re_c, mem_we_c, iord_c, ir_we_c, pc_we_c, pc_src_c;
    logic alu_src_imm_c, reg_we_c, mem_to_reg_c, illegal_c;
    logic retire;

    // DECODE classifies straight from instr: the latched fields only update at the DECODE edge.
    logic [2:0] dec_op;
    logic [3:0] dec_func;
    logic       dec_rtype_ok;
    logic       dec_illegal;
    logic       unused_instr;

    assign dec_op       = instr[15:13];
    assign dec_func     = instr[3:0];
    // Legal R-type funcs are 0..7 except 0010.
    assign dec_rtype_ok = (dec_func[3] == 1'b0) && (dec_func != 4'b0010);
    assign dec_illegal  = (dec_op == OP_BAD) || ((dec_op == OP_RTYPE) && !dec_rtype_ok);
    assign unused_instr = ^instr[12:4];

    always_comb begin
        state_nxt     = state;
        mem_re_c      = 1'b0;
        mem_we_c      = 1'b0;
        iord_c        = 1'b0;
        ir_we_c       = 1'b0;
        pc_we_c       = 1'b0;
        pc_src_c      = 1'b0;
        alu_src_imm_c = 1'b0;
        reg_we_c      = 1'b0;
        mem_to_reg_c  = 1'b0;
        illegal_c     = 1'b0;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_re_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c   = 1'b1;
                    pc_we_c   = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    // Undefined encodings retire as a nop.
                    illegal_c = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (dec_op == OP_HALT) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_imm_c = (opcode == OP_ADDI) || (opcode == OP_SUBI) ||
                                (opcode == OP_ST)   || (opcode == OP_LD);
                if (opcode == OP_BEQ) begin
                    pc_we_c   = zero;
                    pc_src_c  = zero;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                iord_c   = 1'b1;
                mem_re_c = (opcode == OP_LD);
                mem_we_c = (opcode == OP_ST);
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c     = 1'b1;
                mem_to_reg_c = (opcode == OP_LD);
                retire       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Reset kills every strobe in the same cycle so an aborted access never completes.
    assign mem_re      = mem_re_c      & ~rst;
    assign mem_we      = mem_we_c      & ~rst;
    assign iord        = iord_c        & ~rst;
    assign ir_we       = ir_we_c       & ~rst;
    assign pc_we       = pc_we_c       & ~rst;
    assign pc_src      = pc_src_c      & ~rst;
    assign alu_src_imm = alu_src_imm_c & ~rst;
    assign reg_we      = reg_we_c      & ~rst;
    assign mem_to_reg  = mem_to_reg_c  & ~rst;
    assign illegal     = illegal_c     & ~rst;
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            opcode  <= 3'b000;
            func    <= 4'b0000;
            retired <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                opcode <= dec_op;
                func   <= dec_func;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic        mem_re, mem_we, iord, ir_we, pc_we, pc_src;
    logic        alu_src_imm, reg_we, mem_to_reg, illegal, halted;
    logic [15:0] retired;

    ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .opcode(opcode), .func(func), .mem_re(mem_re), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
        .reg_we(reg_we), .mem_to_reg(mem_to_reg), .illegal(illegal), .halted(halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected per-instruction footprint: cycles and number of cycles each output is high.
    typedef struct {
        int          cyc, mre, mwe, iord, irwe, pcwe, br, regwe, m2r, imm, ill;
        logic [15:0] ret;
        logic [2:0]  op;
        logic [3:0]  fn;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_ret = 16'h0000;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, int'({mem_re, mem_we, ir_we, pc_we, pc_src, iord, alu_src_imm,
                      reg_we, mem_to_reg, illegal}), 0);
    endtask

    // Reference model: CPI table plus per-class strobe footprint, fw/mw = wait cycles.
    function automatic exp_t model(input logic [15:0] i, input int fw, input int mw, input logic z);
        exp_t       e;
        logic [2:0] op;
        logic [3:0] fn;
        bit         rtype, ill;
        op    = i[15:13];
        fn    = i[3:0];
        rtype = (op == 3'd0) && (fn inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
        ill   = (op == 3'd5) || ((op == 3'd0) && !rtype);
        e = '{cyc: 0, mre: 0, mwe: 0, iord: 0, irwe: 1, pcwe: 1, br: 0, regwe: 0, m2r: 0,
              imm: 0, ill: 0, ret: 16'h0, op: op, fn: fn};
        e.mre = fw + 1;
        if (ill)              e.cyc = 2;
        else if (op == 3'd7)  e.cyc = 2;
        else if (op == 3'd6)  e.cyc = 3;
        else if (op == 3'd4)  e.cyc = 5;
        else                  e.cyc = 4;
        e.cyc = e.cyc + fw + (((op == 3'd3) || (op == 3'd4)) && !ill ? mw : 0);
        if (ill) e.ill = 1;
        if (!ill && op inside {3'd1, 3'd2, 3'd3, 3'd4}) e.imm = 1;
        if (!ill && (op inside {3'd0, 3'd1, 3'd2, 3'd4})) e.regwe = 1;
        if (op == 3'd4) begin e.m2r = 1; e.mre += mw + 1; e.iord = mw + 1; end
        if (op == 3'd3) begin e.mwe = mw + 1; e.iord = mw + 1; end
        if (op == 3'd6 && z) begin e.br = 1; e.pcwe = 2; end
        return e;
    endfunction

    // Monitor: accumulates output activity; each retirement closes one instruction.
    int          a_cyc, a_mre, a_mwe, a_iord, a_irwe, a_pcwe, a_br, a_regwe, a_m2r, a_imm, a_ill;
    logic [15:0] mon_prev;
    exp_t        me;

    task automatic clear_acc();
        a_cyc = 0; a_mre = 0; a_mwe = 0; a_iord = 0; a_irwe = 0; a_pcwe = 0;
        a_br = 0; a_regwe = 0; a_m2r = 0; a_imm = 0; a_ill = 0;
    endtask

    always @(negedge clk) begin
        if (!mon_en) begin
            clear_acc();
            mon_prev = retired;
        end else begin
            if (retired !== mon_prev) begin
                mon_prev = retired;
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("cycles", a_cyc, me.cyc);
                    chk("mem_re_cycles", a_mre, me.mre);
                    chk("mem_we_cycles", a_mwe, me.mwe);
                    chk("iord_cycles", a_iord, me.iord);
                    chk("ir_we_count", a_irwe, me.irwe);
                    chk("pc_we_count", a_pcwe, me.pcwe);
                    chk("branch_count", a_br, me.br);
                    chk("reg_we_count", a_regwe, me.regwe);
                    chk("mem_to_reg_count", a_m2r, me.m2r);
                    chk("alu_src_imm_count", a_imm, me.imm);
                    chk("illegal_count", a_ill, me.ill);
                    chk("retired", int'(retired), int'(me.ret));
                    chk("opcode", int'(opcode), int'(me.op));
                    chk("func", int'(func), int'(me.fn));
                end
                clear_acc();
            end
            a_cyc++;
            a_mre   += int'(mem_re);
            a_mwe   += int'(mem_we);
            a_iord  += int'(iord & (mem_re | mem_we));
            a_irwe  += int'(ir_we);
            a_pcwe  += int'(pc_we);
            a_br    += int'(pc_we & pc_src);
            a_regwe += int'(reg_we);
            a_m2r   += int'(reg_we & mem_to_reg);
            a_imm   += int'(alu_src_imm);
            a_ill   += int'(illegal);
            chk("re_we_exclusive", int'(mem_re & mem_we), 0);
            chk("reg_mem_exclusive", int'(reg_we & mem_we), 0);
        end
    end

    // Driver: starts at posedge+1 with the DUT in FETCH; acts as memory with planned waits.
    task automatic run(input logic [15:0] i, input int fw, input int mw, input logic z);
        exp_t        e;
        logic [15:0] prev;
        int          cnt;
        bit          done;
        exp_ret = exp_ret + 16'd1;
        e = model(i, fw, mw, z);
        e.ret = exp_ret;
        sb.push_back(e);
        instr = i;
        zero  = z;
        prev  = retired;
        cnt   = 0;
        done  = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (mem_re | mem_we) begin
                if (cnt == (iord ? mw : fw)) begin mem_ready = 1'b1; cnt = 0; end
                else begin mem_ready = 1'b0; cnt++; end
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
            if (retired !== prev) done = 1'b1;
        end
        mem_ready = 1'b0;
        if (!done) chk("run_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] ri;
        mem_ready = 1'b1;
        zero      = 1'b1;
        instr     = 16'h8000;

        // Reset: strobes gated even with mem_ready high in FETCH.
        @(posedge clk);
        @(negedge clk);
        chk_quiet("reset_strobes");
        chk("reset_opcode", int'(opcode), 0);
        chk("reset_func", int'(func), 0);
        chk("reset_retired", int'(retired), 0);
        chk("reset_halted", int'(halted), 0);
        step();
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("first_fetch_mem_re", int'(mem_re), 1);
        chk("first_fetch_iord", int'(iord), 0);
        chk("first_fetch_ir_we", int'(ir_we), 0);
        step();
        mon_en = 1'b1;

        // Directed instructions from the test plan.
        run(16'h0000, 0, 0, 1'b0);   // add
        run(16'h8005, 0, 2, 1'b0);   // ld, 2 MEM waits
        run(16'hC000, 0, 0, 1'b1);   // beq taken
        run(16'hC000, 0, 0, 1'b0);   // beq not taken
        run(16'hA000, 0, 0, 1'b0);   // opcode 101
        run(16'h0002, 0, 0, 1'b0);   // R-type func 0010
        run(16'h6001, 1, 1, 1'b0);   // st with waits
        run(16'h2004, 2, 0, 1'b0);   // addi
        run(16'h4007, 0, 0, 1'b1);   // subi

        // Random stream, halt excluded.
        for (int n = 0; n < 150; n++) begin
            ri = 16'($urandom);
            ri[15:13] = 3'($urandom_range(0, 6));
            run(ri, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        step();
        step();
        mon_en = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);

        // Reset during a FETCH wait.
        @(negedge clk);
        chk("fetch_wait_mem_re", int'(mem_re), 1);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk_quiet("rst_fetch_gated");
        step();
        rst = 1'b0;
        mem_ready = 1'b0;
        exp_ret = 16'h0000;
        @(negedge clk);
        chk("after_rst_ir_we", int'(ir_we), 0);
        chk("after_rst_mem_re", int'(mem_re), 1);
        chk("after_rst_retired", int'(retired), 0);

        // Reset during a ld MEM wait aborts without retirement.
        step();
        instr = 16'h8001;
        mem_ready = 1'b1;
        step();                       // DECODE
        mem_ready = 1'b0;
        step();                       // EXEC
        step();                       // MEM, waiting
        @(negedge clk);
        chk("ld_wait_mem_re", int'(mem_re), 1);
        chk("ld_wait_iord", int'(iord), 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rst_mem_gated");
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_retired", int'(retired), 0);
        chk("abort_fetch_iord", int'(iord), 0);
        chk("abort_fetch_mem_re", int'(mem_re), 1);

        // Counter wrap: preload near the top while FETCH is stalled.
        step();
        force dut.retired = 16'hFFFE;
        step();
        release dut.retired;
        @(negedge clk);
        chk("preload_retired", int'(retired), 16'hFFFE);
        exp_ret = 16'hFFFE;
        step();
        mon_en = 1'b1;
        run(16'hA123, 0, 0, 1'b0);   // -> FFFF
        run(16'h0002, 1, 0, 1'b0);   // -> 0000
        run(16'h000F, 0, 0, 1'b0);   // -> 0001

        // Halt: absorbing until reset.
        run(16'hE000, 1, 0, 1'b0);
        step();
        mon_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            instr     = 16'($urandom);
            zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_halted", int'(halted), 1);
            chk_quiet("halt_strobes");
            step();
        end
        chk("halt_retired", int'(retired), int'(exp_ret));
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("unhalt_halted", int'(halted), 0);
        chk("unhalt_retired", int'(retired), 0);
        chk("unhalt_mem_re", int'(mem_re), 1);
        chk("unhalt_opcode", int'(opcode), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
